// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_pkg
// Description : Shared types and default constants for the pc_gen fetch PC
//               generator (state encoding, next-PC source encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

   localparam int unsigned DEF_XLEN         = 32;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0100_0000;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      SRC_SEQ      = 3'd0,
      SRC_REDIRECT = 3'd1,
      SRC_TRAP     = 3'd2,
      SRC_RAS      = 3'd3,
      SRC_HOLD     = 3'd4
   } src_e;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_gen_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_ras
// Description : Circular return-address stack; push on a full stack
//               overwrites the oldest entry, pop+push replaces the top.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen_ras
   import pc_gen_pkg::*;
#(
   parameter int unsigned XLEN  = DEF_XLEN,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] top_o,
   output logic            empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            wr_en;
   logic [PW-1:0]   wr_idx;
   logic            pop_eff;
   logic [PW-1:0]   top_idx;

   assign empty_o = (count_q == '0);
   assign pop_eff = pop_i & ~empty_o;
   assign top_idx = ptr_q - PW'(1);
   assign top_o   = mem_q[top_idx];

   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      wr_en   = 1'b0;
      wr_idx  = ptr_q;
      if (pop_eff && push_i) begin
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (pop_eff) begin
         ptr_d   = ptr_q - PW'(1);
         count_d = count_q - CW'(1);
      end else if (push_i) begin
         wr_en = 1'b1;
         ptr_d = ptr_q + PW'(1);
         // Saturating count: once full, the pointer wraps onto the oldest entry.
         if (count_q != CW'(DEPTH)) begin
            count_d = count_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
         if (wr_en) begin
            mem_q[wr_idx] <= data_i;
         end
      end
   end

endmodule : pc_gen_ras
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Fetch-stage program-counter generator with trap/redirect,
//               halt/resume and optional return-address stack (PC_GEN_RAS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN         = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
   parameter int unsigned     INSTR_BYTES  = 4,
   parameter int unsigned     RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_valid_o,
   input  logic            pc_ready_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_target_i,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_vector_i,
   input  logic            halt_i,
   input  logic            resume_i,
   output logic            misalign_o,
   output logic            halted_o,
   input  logic            call_i,
   input  logic            ret_i
);

   localparam logic [XLEN-1:0] INC      = XLEN'(INSTR_BYTES);
   localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);

   state_e          state_q, state_d;
   src_e            src;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic            misalign_q, misalign_d;
   logic            halted_q, halted_d;
   logic            boot_q, boot_d;
   logic [XLEN-1:0] pc_seq;
   logic            ras_push, ras_pop;
   logic            ras_hit;
   logic [XLEN-1:0] ras_top;

   assign pc_seq = pc_q + INC;

`ifdef PC_GEN_RAS_EN
   logic ras_empty;

   pc_gen_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .data_i  (pc_seq),
      .top_o   (ras_top),
      .empty_o (ras_empty)
   );

   assign ras_hit = ret_i & pc_ready_i & ~ras_empty;
`else
   logic unused_ras;

   assign ras_hit    = 1'b0;
   assign ras_top    = '0;
   assign unused_ras = &{1'b0, call_i, ret_i, ras_push, ras_pop, RAS_DEPTH[0]};
`endif

   always_comb begin
      state_d    = state_q;
      boot_d     = boot_q;
      src        = SRC_HOLD;
      pc_d       = pc_q;
      misalign_d = 1'b0;
      ras_push   = 1'b0;
      ras_pop    = 1'b0;

      case (state_q)
         // BOOT spans one full idle cycle after the first edge out of reset.
         ST_BOOT: begin
            if (boot_q) begin
               state_d = ST_RUN;
            end else begin
               boot_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (trap_i) begin
               src = SRC_TRAP;
            end else if (redirect_i) begin
               src = SRC_REDIRECT;
            end else if (halt_i) begin
               src = SRC_HOLD;
            end else if (ras_hit) begin
               src = SRC_RAS;
            end else if (pc_ready_i) begin
               src = SRC_SEQ;
            end
            if (halt_i) begin
               state_d = ST_HALT;
            end
            if (src == SRC_SEQ || src == SRC_RAS) begin
               ras_push = call_i;
               ras_pop  = (src == SRC_RAS);
            end
         end
         ST_HALT: begin
            if (trap_i) begin
               src     = SRC_TRAP;
               state_d = ST_RUN;
            end else if (resume_i) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      case (src)
         SRC_TRAP: begin
            pc_d       = trap_vector_i & ~LOW_MASK;
            misalign_d = |(trap_vector_i & LOW_MASK);
         end
         SRC_REDIRECT: begin
            pc_d       = redirect_target_i & ~LOW_MASK;
            misalign_d = |(redirect_target_i & LOW_MASK);
         end
         SRC_RAS:  pc_d = ras_top;
         SRC_SEQ:  pc_d = pc_seq;
         default:  pc_d = pc_q;
      endcase

      valid_d  = (state_d == ST_RUN);
      halted_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         boot_q     <= 1'b0;
         pc_q       <= RESET_VECTOR;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_q     <= boot_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
         halted_q   <= halted_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_valid_o = valid_q;
   assign misalign_o = misalign_q;
   assign halted_o   = halted_q;

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Directed self-checking bench for pc_gen (RAS steps enabled
//               with PC_GEN_RAS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_o;
   logic        pc_valid_o;
   logic        pc_ready_i;
   logic        redirect_i;
   logic [31:0] redirect_target_i;
   logic        trap_i;
   logic [31:0] trap_vector_i;
   logic        halt_i;
   logic        resume_i;
   logic        misalign_o;
   logic        halted_o;
   logic        call_i;
   logic        ret_i;

   int checks = 0;
   int errors = 0;

   pc_gen #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0100_0000),
      .INSTR_BYTES  (4),
      .RAS_DEPTH    (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .pc_o              (pc_o),
      .pc_valid_o        (pc_valid_o),
      .pc_ready_i        (pc_ready_i),
      .redirect_i        (redirect_i),
      .redirect_target_i (redirect_target_i),
      .trap_i            (trap_i),
      .trap_vector_i     (trap_vector_i),
      .halt_i            (halt_i),
      .resume_i          (resume_i),
      .misalign_o        (misalign_o),
      .halted_o          (halted_o),
      .call_i            (call_i),
      .ret_i             (ret_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected pc, valid, halted, misalign after the current edge.
   task automatic chk_all(input string tag, input logic [31:0] pc,
                          input logic v, input logic h, input logic m);
      chk({tag, ".pc"}, pc_o, pc);
      chk({tag, ".valid"}, {31'd0, pc_valid_o}, {31'd0, v});
      chk({tag, ".halted"}, {31'd0, halted_o}, {31'd0, h});
      chk({tag, ".misalign"}, {31'd0, misalign_o}, {31'd0, m});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pc_ready_i = 1'b0; redirect_i = 1'b0; trap_i = 1'b0;
      halt_i = 1'b0; resume_i = 1'b0; call_i = 1'b0; ret_i = 1'b0;
   endtask

   task automatic redirect_to(input logic [31:0] t);
      idle();
      redirect_i = 1'b1; redirect_target_i = t;
      step();
      idle();
   endtask

   initial begin
      rst = 1'b1;
      redirect_target_i = '0;
      trap_vector_i = '0;
      idle();
      #3;
      chk_all("reset_async", 32'h0100_0000, 1'b0, 1'b0, 1'b0);
      step(); step();
      @(negedge clk);
      rst = 1'b0;
      pc_ready_i = 1'b1;
      step();
      chk_all("boot_idle", 32'h0100_0000, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("run_first", 32'h0100_0000, 1'b1, 1'b0, 1'b0);
      step();
      chk("seq_1", pc_o, 32'h0100_0004);
      step();
      chk("seq_2", pc_o, 32'h0100_0008);

      // Backpressure then wrap past the top of the address space.
      redirect_to(32'hFFFF_FFFC);
      chk_all("redir_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold", pc_o, 32'hFFFF_FFFC);
      end
      pc_ready_i = 1'b1;
      step();
      chk_all("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b0);

      // Trap beats redirect; halt in the same cycle still enters HALT.
      idle();
      trap_i = 1'b1; trap_vector_i = 32'h80;
      redirect_i = 1'b1; redirect_target_i = 32'h2002;
      halt_i = 1'b1; pc_ready_i = 1'b1;
      step();
      chk_all("prio_trap_halt", 32'h80, 1'b0, 1'b1, 1'b0);
      idle();
      resume_i = 1'b1;
      step();
      chk_all("resume_80", 32'h80, 1'b1, 1'b0, 1'b0);
      idle();
      redirect_i = 1'b1; redirect_target_i = 32'h2002;
      step();
      chk_all("misalign_redir", 32'h2000, 1'b1, 1'b0, 1'b1);
      idle();
      step();
      chk_all("misalign_clear", 32'h2000, 1'b1, 1'b0, 1'b0);

      // Halt at 0x100, redirect ignored while halted, resume, trap from HALT.
      redirect_to(32'h100);
      halt_i = 1'b1; pc_ready_i = 1'b1;
      step();
      chk_all("halt_enter", 32'h100, 1'b0, 1'b1, 1'b0);
      idle();
      redirect_i = 1'b1; redirect_target_i = 32'h500; pc_ready_i = 1'b1;
      step();
      chk_all("halt_redir_ign", 32'h100, 1'b0, 1'b1, 1'b0);
      idle();
      resume_i = 1'b1;
      step();
      chk_all("halt_resume", 32'h100, 1'b1, 1'b0, 1'b0);
      idle();
      halt_i = 1'b1;
      step();
      idle();
      trap_i = 1'b1; trap_vector_i = 32'h206;
      step();
      chk_all("halt_trap", 32'h204, 1'b1, 1'b0, 1'b1);
      idle();
      pc_ready_i = 1'b1;
      step();
      chk_all("after_trap_seq", 32'h208, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of HALT.
      idle();
      halt_i = 1'b1;
      step();
      chk("pre_rst_halted", {31'd0, halted_o}, 32'd1);
      idle();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_all("rst_mid_halt", 32'h0100_0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      pc_ready_i = 1'b1;
      step();
      chk_all("reboot_idle", 32'h0100_0000, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("reboot_run", 32'h0100_0000, 1'b1, 1'b0, 1'b0);

`ifdef PC_GEN_RAS_EN
      // Five calls into a 4-deep stack: the oldest (0x14) is overwritten.
      for (int i = 1; i <= 5; i++) begin
         redirect_to(32'h10 * i);
         call_i = 1'b1; pc_ready_i = 1'b1;
         step();
         chk("call_seq", pc_o, 32'h10 * i + 32'h4);
         idle();
      end
      ret_i = 1'b1; pc_ready_i = 1'b1;
      step();
      chk("ret_1", pc_o, 32'h54);
      step();
      chk("ret_2", pc_o, 32'h44);
      step();
      chk("ret_3", pc_o, 32'h34);
      step();
      chk("ret_4", pc_o, 32'h24);
      step();
      chk("ret_empty_seq", pc_o, 32'h28);
      idle();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

endmodule : tb_pc_gen
`default_nettype wire
